// File: rtl/clk_div_pkg.sv
// Shared types, limits and helpers for the switch-selectable clock divider.
package clk_div_pkg;

  typedef logic [1:0] sel_t;

  localparam int unsigned MIN_DIV       = 2;
  localparam int unsigned MAX_LEGAL_DIV = 65535;

  // Ratio chosen by the two-bit switch
  function automatic int unsigned div_sel(input sel_t sel,
                                          input int unsigned d0,
                                          input int unsigned d1,
                                          input int unsigned d2,
                                          input int unsigned d3);
    int unsigned r;
    case (sel)
      2'b00:   r = d0;
      2'b01:   r = d1;
      2'b10:   r = d2;
      default: r = d3;
    endcase
    return r;
  endfunction

  // Length of the high phase: ceil(n/2), so odd ratios get the extra cycle high
  function automatic int unsigned half_hi(input int unsigned n);
    return (n + 32'd1) / 32'd2;
  endfunction

  function automatic int unsigned max4(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c,
                                       input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter: holds the position in the period, the active ratio and the
// post-reset start flag, and flags the reload edge.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned CW      = 3,
  parameter int unsigned NW      = 4,
  parameter int unsigned RESET_N = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NW-1:0] n_new,
  output logic          reload,
  output logic [CW-1:0] cnt_next,
  output logic [NW-1:0] n_q
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] n_d;
  logic          start_q, start_d;

  // Reload on the first edge after reset or on the last cycle of a period
  assign reload   = start_q || (NW'(cnt_q) == (n_q - NW'(1)));
  assign cnt_next = cnt_q + CW'(1);

  always_comb begin
    cnt_d   = cnt_q;
    n_d     = n_q;
    start_d = start_q;
    if (reload) begin
      cnt_d   = '0;
      n_d     = n_new;
      start_d = 1'b0;
    end else begin
      cnt_d   = cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      n_q     <= NW'(RESET_N);
      start_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      start_q <= start_d;
    end
  end

endmodule

// File: rtl/clk_div_sel.sv
// Switch-selectable integer clock divider with glitch-free ratio changes.
// Define CLK_DIV_TICK_EN to add a one-cycle-per-period tick output.
module clk_div_sel
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV0 = 2,
  parameter int unsigned DIV1 = 3,
  parameter int unsigned DIV2 = 5,
  parameter int unsigned DIV3 = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  output logic       clk_out
`ifdef CLK_DIV_TICK_EN
  ,
  output logic       tick
`endif
);

  localparam int unsigned MAX_DIV = max4(DIV0, DIV1, DIV2, DIV3);
  localparam int unsigned CW      = $clog2(MAX_DIV);
  localparam int unsigned NW      = $clog2(MAX_DIV + 1);

  if (DIV0 < MIN_DIV || DIV1 < MIN_DIV || DIV2 < MIN_DIV || DIV3 < MIN_DIV ||
      DIV0 > MAX_LEGAL_DIV || DIV1 > MAX_LEGAL_DIV ||
      DIV2 > MAX_LEGAL_DIV || DIV3 > MAX_LEGAL_DIV) begin : g_bad_div
    $error("clk_div_sel: every DIVx must lie in 2..65535");
  end

  logic [NW-1:0] n_new;
  logic [NW-1:0] n_q;
  logic [CW-1:0] cnt_next;
  logic          reload;
  logic          clk_out_q, clk_out_d;

  // sw only matters on reload edges; the counter ignores n_new otherwise
  assign n_new = NW'(div_sel(sel_t'(sw), DIV0, DIV1, DIV2, DIV3));

  clk_div_counter #(
    .CW      (CW),
    .NW      (NW),
    .RESET_N (DIV0)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .n_new    (n_new),
    .reload   (reload),
    .cnt_next (cnt_next),
    .n_q      (n_q)
  );

  always_comb begin
    clk_out_d = clk_out_q;
    if (reload) begin
      clk_out_d = 1'b1;
    end else begin
      clk_out_d = (32'(cnt_next) < half_hi(32'(n_q)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_out_q <= 1'b0;
    end else begin
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

`ifdef CLK_DIV_TICK_EN
  logic tick_q, tick_d;

  always_comb begin
    tick_d = reload;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
`endif

endmodule

// File: tb/tb_clk_div_sel.sv
// Directed plus randomized bench for clk_div_sel against a waveform-queue model.
module tb_clk_div_sel;

  logic       clk;
  logic       rst;
  logic [1:0] sw;
  logic       clk_out;
`ifdef CLK_DIV_TICK_EN
  logic       tick;
`endif

  clk_div_sel dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .clk_out (clk_out)
`ifdef CLK_DIV_TICK_EN
    ,
    .tick    (tick)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic first;
    logic level;
  } samp_t;

  int unsigned divs [4] = '{2, 3, 5, 8};
  samp_t       exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          rises  = 0;
  logic        prev_out = 1'b0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: when the current period is used up, the switch value at that edge
  // defines the whole next period as ceil(N/2) highs followed by floor(N/2) lows.
  task automatic edge_step(input logic [1:0] s, input string tag);
    samp_t e;
    int unsigned n;
    sw = s;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n = divs[s];
      for (int i = 0; i < int'(n); i++) begin
        e.first = (i == 0);
        e.level = (i < int'((n + 1) / 2));
        exp_q.push_back(e);
      end
    end
    e = exp_q.pop_front();
    check_bit(tag, clk_out, e.level);
`ifdef CLK_DIV_TICK_EN
    check_bit({tag, "_tick"}, tick, e.first);
`endif
    if (clk_out && !prev_out) rises++;
    prev_out = clk_out;
  endtask

  task automatic run_edges(input logic [1:0] s, input int n, input string tag);
    for (int i = 0; i < n; i++) edge_step(s, tag);
  endtask

  // Reset raised between edges, held across one edge, released on a negedge
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_bit("rst_async", clk_out, 1'b0);
`ifdef CLK_DIV_TICK_EN
    check_bit("rst_tick", tick, 1'b0);
`endif
    @(posedge clk);
    #1;
    check_bit("rst_hold", clk_out, 1'b0);
    exp_q.delete();
    prev_out = 1'b0;
    rises    = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] s;
    rst = 1'b1;
    sw  = 2'b00;
    #2;
    check_bit("por_clk_out", clk_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Ratio 2: square wave from edge 1
    run_edges(2'b00, 30, "div2");
    check_int("div2_rises", rises, 15);

    do_reset();
    run_edges(2'b01, 30, "div3");
    check_int("div3_rises", rises, 10);

    do_reset();
    run_edges(2'b10, 30, "div5");
    check_int("div5_rises", rises, 6);

    do_reset();
    run_edges(2'b11, 30, "div8");
    check_int("div8_rises", rises, 4);
    check_bit("div8_end_low", clk_out, 1'b0);

    // Switch 8 -> 2 with cnt=2: old period must finish 4 high / 4 low
    do_reset();
    run_edges(2'b11, 3, "sw_pre");
    run_edges(2'b00, 5, "sw_tail");
    check_bit("sw_tail_low", clk_out, 1'b0);
    run_edges(2'b00, 6, "sw_new");
    check_int("sw_rises", rises, 4);

    // Reset mid-period, then edge 1 gives clk_out=1
    run_edges(2'b10, 2, "mid");
    do_reset();
    edge_step(2'b01, "post_rst");
    check_bit("post_rst_high", clk_out, 1'b1);

    // Switch changed during reset takes effect on the first edge
    @(negedge clk);
    rst = 1'b1;
    sw  = 2'b00;
    #1;
    check_bit("rst_sw_async", clk_out, 1'b0);
    exp_q.delete();
    prev_out = 1'b0;
    sw = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    run_edges(2'b11, 8, "rst_sw");

    // Randomized switch activity with occasional asynchronous resets
    s = 2'($urandom_range(0, 3));
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      if ($urandom_range(0, 6) == 0) s = 2'($urandom_range(0, 3));
      edge_step(s, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
